// File: rtl/addsub_pkg.sv
// Shared helpers for the pipelined add/subtract unit: slice geometry, the
// signed-overflow rule and the output flag bundle.
package addsub_pkg;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // LSB index of slice k inside the full-width operand.
  function automatic int slice_range(input int k, input int cw);
    return k * cw;
  endfunction

  function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                           input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// One CW-bit slice of the carry chain; sum and carry-out are registered
// together and only update when the pipeline advances.
module addsub_slice #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] a_s,
  input  logic [CW-1:0] b_s,
  input  logic          c_in,
  output logic [CW-1:0] s_s,
  output logic          c_out
);

  logic [CW:0]   total_d;
  logic [CW-1:0] s_q;
  logic          c_q;

  assign total_d = {1'b0, a_s} + {1'b0, b_s} + {{CW{1'b0}}, c_in};

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else if (en) begin
      s_q <= total_d[CW-1:0];
      c_q <= total_d[CW];
    end
  end

  assign s_s   = s_q;
  assign c_out = c_q;

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into STAGES carry-chained slices with operand
// skew, result deskew and valid/ready flow control. ADDSUB_SAT_EN adds saturation.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CW = slice_width(WIDTH, STAGES);

  // Per-stage control travelling with each beat; its width follows TAG_W.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic [TAG_W-1:0] tag;
`ifdef ADDSUB_SAT_EN
    logic             sat;
`endif
  } stage_ctl_t;

  logic              adv;
  stage_ctl_t        ctl_d;
  stage_ctl_t        ctl_q [STAGES];
  stage_ctl_t        ctl_out;
  logic [STAGES-1:0] carry_w;
  logic [CW-1:0]     slice_sum_w [STAGES];
  logic [WIDTH-1:0]  sum_raw;
  logic              msb_a_q;
  logic              msb_b_q;
  logic              b_eff_msb;
  logic              ovf_w;
  logic [WIDTH-1:0]  sum_fin;
  flags_t            flags;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;

  // NOTE: defaulting every always_comb output first keeps the block latch-free.
  always_comb begin
    ctl_d       = '0;
    ctl_d.valid = in_valid && in_ready;
    ctl_d.sub   = sub;
    ctl_d.tag   = tag;
`ifdef ADDSUB_SAT_EN
    ctl_d.sat   = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) ctl_q[i] <= '0;
    end else if (adv) begin
      ctl_q[0] <= ctl_d;
      for (int i = 1; i < STAGES; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam int LSB = slice_range(k, CW);
    localparam int DSK = STAGES - 1 - k;

    logic [CW-1:0] a_op;
    logic [CW-1:0] b_raw;
    logic [CW-1:0] b_op;
    logic          sub_op;
    logic          c_op;

    if (k == 0) begin : g_head
      assign a_op   = a[LSB +: CW];
      assign b_raw  = b[LSB +: CW];
      assign sub_op = sub;
      assign c_op   = cin ^ sub;
    end else begin : g_skew
      logic [CW-1:0] a_sr_q [k];
      logic [CW-1:0] b_sr_q [k];

      // NOTE: skew/deskew registers are cleared too, so a flushed beat leaves no stale data behind.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < k; j++) begin
            a_sr_q[j] <= '0;
            b_sr_q[j] <= '0;
          end
        end else if (adv) begin
          a_sr_q[0] <= a[LSB +: CW];
          b_sr_q[0] <= b[LSB +: CW];
          for (int j = 1; j < k; j++) begin
            a_sr_q[j] <= a_sr_q[j-1];
            b_sr_q[j] <= b_sr_q[j-1];
          end
        end
      end

      assign a_op   = a_sr_q[k-1];
      assign b_raw  = b_sr_q[k-1];
      assign sub_op = ctl_q[k-1].sub;
      assign c_op   = carry_w[k-1];
    end

    assign b_op = sub_op ? ~b_raw : b_raw;

    addsub_slice #(.CW(CW)) u_slice (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .a_s   (a_op),
      .b_s   (b_op),
      .c_in  (c_op),
      .s_s   (slice_sum_w[k]),
      .c_out (carry_w[k])
    );

    if (DSK == 0) begin : g_nodsk
      assign sum_raw[LSB +: CW] = slice_sum_w[k];
    end else begin : g_dsk
      logic [CW-1:0] dsk_q [DSK];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < DSK; j++) dsk_q[j] <= '0;
        end else if (adv) begin
          dsk_q[0] <= slice_sum_w[k];
          for (int j = 1; j < DSK; j++) dsk_q[j] <= dsk_q[j-1];
        end
      end

      assign sum_raw[LSB +: CW] = dsk_q[DSK-1];
    end

    // Raw b MSB is kept; the output stage re-applies sub to get the effective sign.
    if (k == STAGES - 1) begin : g_msb
      always_ff @(posedge clk) begin
        if (rst) begin
          msb_a_q <= 1'b0;
          msb_b_q <= 1'b0;
        end else if (adv) begin
          msb_a_q <= a_op[CW-1];
          msb_b_q <= b_raw[CW-1];
        end
      end
    end
  end

  assign ctl_out = ctl_q[STAGES-1];

  always_comb begin
    b_eff_msb = msb_b_q ^ ctl_out.sub;
    ovf_w     = signed_overflow(msb_a_q, b_eff_msb, sum_raw[WIDTH-1]);
    sum_fin   = sum_raw;
`ifdef ADDSUB_SAT_EN
    if (ctl_out.sat && ovf_w) begin
      sum_fin = msb_a_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flags.cout     = carry_w[STAGES-1];
    flags.overflow = ovf_w;
    // Gated by valid so an idle or freshly reset unit does not flag zero.
    flags.zero     = ctl_out.valid && (sum_fin == '0);
  end

  assign out_valid = ctl_out.valid;
  assign tag_out   = ctl_out.tag;
  assign sum       = sum_fin;
  assign cout      = flags.cout;
  assign overflow  = flags.overflow;
  assign zero      = flags.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4): directed vectors,
// a stalled burst and a mid-flight reset; a monitor checks every output beat.
module tb_pipelined_addsub;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 4;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          sat;
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
  } vec_t;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
    int            acc_cyc;
    bit            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic [TW-1:0] tag;
  logic          sat_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;
  logic          zero;
  logic [TW-1:0] tag_out;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  pipelined_addsub #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .tag       (tag),
`ifdef ADDSUB_SAT_EN
    .sat       (sat_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void add_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input logic vcin, input logic vsub, input logic vsat,
                                  input logic [TW-1:0] vtag, input logic [W-1:0] vsum,
                                  input logic vcout, input logic vovf, input logic vzero);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub; v.sat = vsat; v.tag = vtag;
    v.sum = vsum; v.cout = vcout; v.ovf = vovf; v.zero = vzero;
    vecs.push_back(v);
  endfunction

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_sum"},       sum,       0);
    check({pfx, "_cout"},      cout,      0);
    check({pfx, "_overflow"},  overflow,  0);
    check({pfx, "_zero"},      zero,      0);
    check({pfx, "_tag_out"},   tag_out,   0);
  endtask

  // Issues vecs[first +: count]; out_ready is low for relative cycles stall_lo..stall_hi.
  task automatic run_beats(input int first, input int count, input int stall_lo,
                           input int stall_hi, input bit lat);
    int idx = first;
    int rel = 0;
    while ((idx < first + count || rel <= stall_hi) && rel < 100) begin
      out_ready = !(rel >= stall_lo && rel <= stall_hi);
      in_valid  = (idx < first + count);
      if (in_valid) begin
        a = vecs[idx].a; b = vecs[idx].b; cin = vecs[idx].cin;
        sub = vecs[idx].sub; sat_in = vecs[idx].sat; tag = vecs[idx].tag;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_t e;
        e.sum = vecs[idx].sum; e.cout = vecs[idx].cout; e.ovf = vecs[idx].ovf;
        e.zero = vecs[idx].zero; e.tag = vecs[idx].tag; e.acc_cyc = cyc; e.lat = lat;
        exp_q.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      rel++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("beats_issued", idx - first, count);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks held outputs during stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && !out_ready) begin
          check("in_ready_during_stall", in_ready, 0);
          if (exp_q.size() != 0) begin
            check("stall_sum_held", sum, exp_q[0].sum);
            check("stall_tag_held", tag_out, exp_q[0].tag);
          end
        end
        if (out_valid && out_ready) begin
          check("result_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sum", sum, e.sum);
            check("cout", cout, e.cout);
            check("overflow", overflow, e.ovf);
            check("zero", zero, e.zero);
            check("tag_out", tag_out, e.tag);
            if (e.lat) check("latency", cyc - e.acc_cyc, LAT);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0; sat_in = 1'b0;

    // 0-7: directed corner cases
    add_vec(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 4'h1, 32'h0000_0000, 1, 0, 1);
    add_vec(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 4'h2, 32'h8000_0000, 0, 1, 0);
    add_vec(32'h0000_0005, 32'h0000_0007, 0, 1, 0, 4'h3, 32'hFFFF_FFFE, 0, 0, 0);
    add_vec(32'h8000_0000, 32'h0000_0001, 0, 1, 0, 4'h4, 32'h7FFF_FFFF, 1, 1, 0);
    add_vec(32'h0000_00FF, 32'h0000_0000, 1, 0, 0, 4'h5, 32'h0000_0100, 0, 0, 0);
    add_vec(32'h0000_000A, 32'h0000_0003, 1, 1, 0, 4'h6, 32'h0000_0006, 1, 0, 0);
    add_vec(32'h1234_5678, 32'h1234_5678, 0, 1, 0, 4'h7, 32'h0000_0000, 1, 0, 1);
    add_vec(32'h8000_0000, 32'h8000_0000, 0, 0, 0, 4'h8, 32'h0000_0000, 1, 1, 1);
    // 8-15: burst with tags 0..7, carries rippling across slice boundaries
    add_vec(32'h0000_0001, 32'h0000_0002, 0, 0, 0, 4'h0, 32'h0000_0003, 0, 0, 0);
    add_vec(32'h0000_00FF, 32'h0000_0001, 0, 0, 0, 4'h1, 32'h0000_0100, 0, 0, 0);
    add_vec(32'h0000_FFFF, 32'h0000_0001, 0, 0, 0, 4'h2, 32'h0001_0000, 0, 0, 0);
    add_vec(32'h00FF_FFFF, 32'h0000_0001, 0, 0, 0, 4'h3, 32'h0100_0000, 0, 0, 0);
    add_vec(32'h0000_0000, 32'h0000_0001, 0, 1, 0, 4'h4, 32'hFFFF_FFFF, 0, 0, 0);
    add_vec(32'h0100_0000, 32'h0000_0001, 0, 1, 0, 4'h5, 32'h00FF_FFFF, 1, 0, 0);
    add_vec(32'h4000_0000, 32'h4000_0000, 0, 0, 0, 4'h6, 32'h8000_0000, 0, 1, 0);
    add_vec(32'h0000_0003, 32'h0000_0002, 1, 1, 0, 4'h7, 32'h0000_0000, 1, 0, 1);
    // 16-18: flushed by reset; 19: fresh beat after reset
    add_vec(32'h1111_1111, 32'h2222_2222, 0, 0, 0, 4'hC, 32'h3333_3333, 0, 0, 0);
    add_vec(32'h0102_0304, 32'h1020_3040, 0, 0, 0, 4'hD, 32'h1122_3344, 0, 0, 0);
    add_vec(32'h5555_5555, 32'h1111_1111, 0, 1, 0, 4'hE, 32'h4444_4444, 1, 0, 0);
    add_vec(32'h0F0F_0F0F, 32'h0101_0101, 1, 0, 0, 4'hA, 32'h1010_1011, 0, 0, 0);
    // 20-21: saturating overflow
    add_vec(32'h7FFF_FFF0, 32'h0000_0020, 0, 0, 1, 4'hB, 32'h7FFF_FFFF, 0, 1, 0);
    add_vec(32'h8000_0000, 32'h0000_0001, 0, 1, 1, 4'hF, 32'h8000_0000, 1, 1, 0);

    @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", in_ready, 0);
    @(posedge clk); #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    run_beats(0, 8, 1, 0, 1'b1);
    wait_drain("drain_directed");

    run_beats(8, 8, 5, 8, 1'b0);
    wait_drain("drain_stalled_burst");

    run_beats(16, 3, 1, 0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("in_ready_mid_reset", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("flush");
    run_beats(19, 1, 1, 0, 1'b1);
    wait_drain("drain_after_reset");
    repeat (10) @(posedge clk);
    #1;

`ifdef ADDSUB_SAT_EN
    run_beats(20, 2, 1, 0, 1'b1);
    wait_drain("drain_saturate");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
